// File: rtl/cpu4_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu4_pkg : opcodes and sequencer state shared by the CPU and sequencer
// Rev 1.0
// ------------------------------------------------------------------
package cpu4_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [3:0] data;
  } instr_t;

endpackage
`default_nettype wire

// File: rtl/cpu4_instr_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu4_instr_sequencer_if : instruction issue handshake toward the CPU core
// Rev 1.0
// ------------------------------------------------------------------
interface cpu4_instr_sequencer_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] out_opcode;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       out_write_ena;

  modport master (
    output issue_valid, out_opcode, out_addr, out_data, out_write_ena,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, out_opcode, out_addr, out_data, out_write_ena,
    output issue_ready
  );
endinterface
`default_nettype wire

// File: rtl/cpu4_prog_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu4_prog_mem : DEPTH x 12 instruction store, sync write, registered read
// Rev 1.0
// ------------------------------------------------------------------
module cpu4_prog_mem #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  wire logic            clk,
  input  wire logic            we,
  input  wire logic [PC_W-1:0] waddr,
  input  wire logic [11:0]     wdata,
  input  wire logic [PC_W-1:0] raddr,
  output logic      [11:0]     rdata
);

  logic [11:0] mem_q [DEPTH];
  logic [11:0] rdata_q;

  // Contents are deliberately left unreset so this maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cpu4_instr_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu4_instr_sequencer : steps a PC through a host-loaded store, issuing to the CPU
// Rev 1.0
// ------------------------------------------------------------------
module cpu4_instr_sequencer
  import cpu4_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              prog_we,
  input  wire logic [PC_W-1:0]   prog_addr,
  input  wire logic [11:0]       prog_word,
  input  wire logic [PC_W:0]     prog_len,
  input  wire logic              start,
  cpu4_instr_sequencer_if.master issue_if,
  output logic      [PC_W-1:0]   pc,
  output logic                   busy,
  output logic                   halted
);

  localparam logic [PC_W:0] LEN_ONE = {{PC_W{1'b0}}, 1'b1};

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  instr_t          instr_q, instr_d;
  instr_t          mem_rdata;

  logic            start_ok;
  logic            last_entry;
  logic            handshake;
  logic            issue_valid;
  logic            busy_w;
  logic            halted_w;
  logic            write_ena;

  assign start_ok   = (state_q == ST_IDLE || state_q == ST_HALT) && start;
  assign handshake  = (state_q == ST_ISSUE) && issue_if.issue_ready;
  assign last_entry = (instr_q.opcode == OP_HALT)
                   || ({1'b0, pc_q} == (len_q - LEN_ONE))
                   || (pc_q == {PC_W{1'b1}});

  // Read address follows pc_d so the word for the new pc is ready in FETCH.
  cpu4_prog_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && !busy_w),
    .waddr (prog_addr),
    .wdata (prog_word),
    .raddr (pc_d),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = (prog_len == '0) ? ST_HALT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = (mem_rdata.opcode == OP_HALT) ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_if.issue_ready) begin
          state_d = last_entry ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = (state_q == ST_ISSUE);
    busy_w      = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    halted_w    = (state_q == ST_HALT);
    write_ena   = issue_valid && (instr_q.opcode == OP_STORE);
  end

  always_comb begin
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    if (start_ok) begin
      pc_d  = '0;
      len_d = prog_len;
    end
    // Bus registers load only in FETCH, which keeps them frozen during ISSUE.
    if (state_q == ST_FETCH && mem_rdata.opcode != OP_HALT) begin
      instr_d = mem_rdata;
    end
    if (handshake && !last_entry) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
    end
  end

  assign issue_if.issue_valid   = issue_valid;
  assign issue_if.out_opcode    = {instr_q.opcode, 4'b0000};
  assign issue_if.out_addr      = {instr_q.addr, 4'b0000};
  assign issue_if.out_data      = {instr_q.data, 4'b0000};
  assign issue_if.out_write_ena = write_ena;

  assign pc     = pc_q;
  assign busy   = busy_w;
  assign halted = halted_w;

endmodule
`default_nettype wire

// File: tb/tb_cpu4_instr_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cpu4_instr_sequencer : directed self-checking bench for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
module tb_cpu4_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_word;
  logic [4:0]  prog_len;
  logic        start;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;

  int checks;
  int failures;

  logic [7:0] op_a   [32];
  logic [7:0] addr_a [32];
  logic [7:0] data_a [32];
  logic       we_a   [32];
  int         n_iss;

  cpu4_instr_sequencer_if u_if ();

  cpu4_instr_sequencer #(.DEPTH(16), .PC_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_word (prog_word),
    .prog_len  (prog_len),
    .start     (start),
    .issue_if  (u_if),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [3:0] a, input logic [11:0] w);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_word = w;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len);
    start    = 1'b1;
    prog_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (u_if.issue_valid) break;
      @(negedge clk);
    end
  endtask

  // Records every accepted instruction until halted or the budget runs out.
  task automatic collect(input int budget);
    n_iss = 0;
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      if (u_if.issue_valid && u_if.issue_ready && n_iss < 32) begin
        op_a[n_iss]   = u_if.out_opcode;
        addr_a[n_iss] = u_if.out_addr;
        data_a[n_iss] = u_if.out_data;
        we_a[n_iss]   = u_if.out_write_ena;
        n_iss++;
      end
      @(negedge clk);
    end
  endtask

  logic [7:0] snap_op, snap_data;
  logic       stable;

  initial begin
    checks = 0; failures = 0; n_iss = 0;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_word = '0;
    prog_len = '0; start = 1'b0; u_if.issue_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid",  u_if.issue_valid, 1'b0);
    chk("rst_pc",     pc, 4'd0);
    chk("rst_opcode", u_if.out_opcode, 8'h00);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_we",     u_if.out_write_ena, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: asynchronous reset while an instruction is waiting for ready
    prog(4'd0, 12'h350);
    prog(4'd1, 12'h002);
    prog(4'd2, 12'h260);
    do_start(5'd3);
    wait_valid(10);
    chk("t1_valid_before", u_if.issue_valid, 1'b1);
    chk("t1_op_before", u_if.out_opcode, 8'h30);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_valid", u_if.issue_valid, 1'b0);
    chk("t1_async_pc", pc, 4'd0);
    chk("t1_async_opcode", u_if.out_opcode, 8'h00);
    chk("t1_async_busy", busy, 1'b0);
    chk("t1_async_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 2: three-instruction program, ready always high
    u_if.issue_ready = 1'b1;
    do_start(5'd3);
    collect(40);
    chk("t2_count", n_iss, 3);
    chk("t2_op0", op_a[0], 8'h30);   chk("t2_op1", op_a[1], 8'h00);   chk("t2_op2", op_a[2], 8'h20);
    chk("t2_ad0", addr_a[0], 8'h50); chk("t2_ad1", addr_a[1], 8'h00); chk("t2_ad2", addr_a[2], 8'h60);
    chk("t2_d0", data_a[0], 8'h00);  chk("t2_d1", data_a[1], 8'h20);  chk("t2_d2", data_a[2], 8'h00);
    chk("t2_we0", we_a[0], 1'b0);    chk("t2_we1", we_a[1], 1'b0);    chk("t2_we2", we_a[2], 1'b1);
    chk("t2_halted", halted, 1'b1);
    chk("t2_pc", pc, 4'd2);
    chk("t2_valid_halt", u_if.issue_valid, 1'b0);

    // Test 3: backpressure on the second instruction
    u_if.issue_ready = 1'b0;
    do_start(5'd3);
    wait_valid(10);
    chk("t3_first_op", u_if.out_opcode, 8'h30);
    u_if.issue_ready = 1'b1;
    @(negedge clk);
    u_if.issue_ready = 1'b0;
    chk("t3_fetch_valid", u_if.issue_valid, 1'b0);
    chk("t3_fetch_pc", pc, 4'd1);
    @(negedge clk);
    snap_op   = u_if.out_opcode;
    snap_data = u_if.out_data;
    stable    = u_if.issue_valid;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stable = stable && u_if.issue_valid && (u_if.out_opcode == snap_op)
            && (u_if.out_data == snap_data) && (pc == 4'd1);
    end
    chk("t3_stable", stable, 1'b1);
    chk("t3_stall_valid", u_if.issue_valid, 1'b1);
    chk("t3_stall_pc", pc, 4'd1);
    chk("t3_stall_op", u_if.out_opcode, 8'h00);
    chk("t3_stall_data", u_if.out_data, 8'h20);
    u_if.issue_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept_valid", u_if.issue_valid, 1'b0);
    chk("t3_accept_pc", pc, 4'd2);
    collect(20);
    chk("t3_tail_count", n_iss, 1);
    chk("t3_tail_op", op_a[0], 8'h20);
    chk("t3_halted", halted, 1'b1);
    chk("t3_pc", pc, 4'd2);

    // Test 4: HALT opcode at index 1 stops the run before it is issued
    prog(4'd0, 12'h123);
    prog(4'd1, 12'hF00);
    prog(4'd2, 12'h456);
    prog(4'd3, 12'h789);
    do_start(5'd4);
    collect(40);
    chk("t4_count", n_iss, 1);
    chk("t4_op0", op_a[0], 8'h10);
    chk("t4_ad0", addr_a[0], 8'h20);
    chk("t4_halted", halted, 1'b1);
    chk("t4_pc", pc, 4'd1);

    // Test 5a: zero length halts on the next cycle
    do_start(5'd0);
    chk("t5a_halted", halted, 1'b1);
    chk("t5a_busy", busy, 1'b0);
    chk("t5a_valid", u_if.issue_valid, 1'b0);
    chk("t5a_pc", pc, 4'd0);

    // Test 5b: full-depth program
    for (int i = 0; i < 16; i++) begin
      prog(4'(i), {4'h6, 4'(i), 4'(15 - i)});
    end
    do_start(5'd16);
    collect(100);
    chk("t5b_count", n_iss, 16);
    chk("t5b_ad0", addr_a[0], 8'h00);
    chk("t5b_d0", data_a[0], 8'hF0);
    chk("t5b_ad15", addr_a[15], 8'hF0);
    chk("t5b_d15", data_a[15], 8'h00);
    chk("t5b_op15", op_a[15], 8'h60);
    chk("t5b_halted", halted, 1'b1);
    chk("t5b_pc", pc, 4'd15);

    // Test 6: writes and start while busy are ignored
    u_if.issue_ready = 1'b0;
    do_start(5'd3);
    wait_valid(10);
    prog_we = 1'b1; prog_addr = 4'd1; prog_word = 12'hABC;
    start = 1'b1; prog_len = 5'd5;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    chk("t6_still_pc", pc, 4'd0);
    u_if.issue_ready = 1'b1;
    collect(40);
    chk("t6_count", n_iss, 3);
    chk("t6_op1", op_a[1], 8'h60);
    chk("t6_ad1", addr_a[1], 8'h10);
    chk("t6_d1", data_a[1], 8'hE0);
    chk("t6_halted", halted, 1'b1);
    chk("t6_pc", pc, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
